// File: rtl/dict_decompressor.sv
`default_nettype none
// ============================================================================
// Module   : dict_decompressor
// Purpose  : Two-stage streaming dictionary decoder. Each token is either a
//            key or a raw value; the block emits full-width values.
// Revision : 1.0 - initial release
// ============================================================================
module dict_decompressor #(
    parameter int KEY_WIDTH = 4,
    parameter int VAL_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 dict_we,
    input  logic [KEY_WIDTH-1:0] dict_waddr,
    input  logic [VAL_WIDTH-1:0] dict_wdata,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_compressed,
    input  logic [VAL_WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [VAL_WIDTH-1:0] out_data,
    output logic                 out_was_compressed,
    output logic                 err_miss,
    output logic [CNT_WIDTH-1:0] stat_compressed,
    output logic [CNT_WIDTH-1:0] stat_raw,
    input  logic                 stat_clear
);

    localparam int c_depth = 1 << KEY_WIDTH;

    logic [VAL_WIDTH-1:0] r_mem [c_depth];
    logic [c_depth-1:0]   r_entry_valid;

    logic                 r_s1_valid;
    logic                 r_s1_comp;
    logic [VAL_WIDTH-1:0] r_s1_data;

    logic                 r_out_valid;
    logic                 r_out_comp;
    logic [VAL_WIDTH-1:0] r_out_data;
    logic                 r_err_miss;
    logic [CNT_WIDTH-1:0] r_stat_comp;
    logic [CNT_WIDTH-1:0] r_stat_raw;

    logic [KEY_WIDTH-1:0] w_key;
    logic                 w_fwd;
    logic                 w_entry_ok;
    logic [VAL_WIDTH-1:0] w_lookup;
    logic [VAL_WIDTH-1:0] w_resolved;
    logic                 w_s2_free;
    logic                 w_s1_adv;
    logic                 w_accept;
    logic                 w_miss;
    logic                 w_out_hs;

    // Array contents need no reset: the per-entry valid bits gate every read.
    always_ff @(posedge clk) begin
        if (dict_we) begin
            r_mem[dict_waddr] <= dict_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_entry_valid <= '0;
        end else if (dict_we) begin
            r_entry_valid[dict_waddr] <= 1'b1;
        end
    end

    // A write landing on the key being resolved is forwarded (write-first).
    assign w_key      = r_s1_data[KEY_WIDTH-1:0];
    assign w_fwd      = dict_we && (dict_waddr == w_key);
    assign w_entry_ok = w_fwd || r_entry_valid[w_key];
    assign w_lookup   = w_fwd ? dict_wdata : r_mem[w_key];

    always_comb begin
        w_resolved = r_s1_data;
        if (r_s1_comp) begin
            w_resolved = w_entry_ok ? w_lookup : '0;
        end
    end

    assign w_s2_free = !r_out_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_free;
    assign w_accept  = in_valid && in_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_free;
    assign w_miss    = w_s1_adv && r_s1_comp && !w_entry_ok;
    assign w_out_hs  = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_s1_valid <= 1'b0;
            r_s1_comp  <= 1'b0;
            r_s1_data  <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_comp  <= in_compressed;
            r_s1_data  <= in_data;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Output registers move only when S2 is free, so held data stays stable.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_out_valid <= 1'b0;
            r_out_comp  <= 1'b0;
            r_out_data  <= '0;
        end else if (w_s2_free) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_comp <= r_s1_comp;
                r_out_data <= w_resolved;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_err_miss  <= 1'b0;
            r_stat_comp <= '0;
            r_stat_raw  <= '0;
        end else begin
            r_err_miss <= w_miss || (r_err_miss && !stat_clear);
            if (stat_clear) begin
                r_stat_comp <= '0;
                r_stat_raw  <= '0;
            end else if (w_out_hs) begin
                if (r_out_comp) begin
                    if (r_stat_comp != '1) begin
                        r_stat_comp <= r_stat_comp + CNT_WIDTH'(1);
                    end
                end else if (r_stat_raw != '1) begin
                    r_stat_raw <= r_stat_raw + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign out_valid          = r_out_valid;
    assign out_data           = r_out_data;
    assign out_was_compressed = r_out_comp;
    assign err_miss           = r_err_miss;
    assign stat_compressed    = r_stat_comp;
    assign stat_raw           = r_stat_raw;

endmodule
`default_nettype wire

// File: tb/tb_dict_decompressor.sv
`default_nettype none
// ============================================================================
// Module   : tb_dict_decompressor
// Purpose  : Directed self-checking bench for dict_decompressor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dict_decompressor;

    logic       clk;
    logic       resetn;
    logic       dict_we;
    logic [3:0] dict_waddr;
    logic [7:0] dict_wdata;
    logic       in_valid;
    logic       in_ready;
    logic       in_compressed;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_was_compressed;
    logic       err_miss;
    logic [15:0] stat_compressed;
    logic [15:0] stat_raw;
    logic       stat_clear;

    // Second instance with narrow counters for the saturation case.
    logic       s_in_valid;
    logic       s_in_ready;
    logic       s_out_valid;
    logic [7:0] s_out_data;
    logic       s_out_comp;
    logic       s_err_miss;
    logic [1:0] s_stat_comp;
    logic [1:0] s_stat_raw;

    int n_cmp;
    int n_err;

    dict_decompressor #(.KEY_WIDTH(4), .VAL_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .resetn(resetn),
        .dict_we(dict_we), .dict_waddr(dict_waddr), .dict_wdata(dict_wdata),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_compressed(in_compressed), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_was_compressed(out_was_compressed), .err_miss(err_miss),
        .stat_compressed(stat_compressed), .stat_raw(stat_raw),
        .stat_clear(stat_clear)
    );

    dict_decompressor #(.KEY_WIDTH(4), .VAL_WIDTH(8), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .resetn(resetn),
        .dict_we(1'b0), .dict_waddr(4'h0), .dict_wdata(8'h00),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_compressed(1'b0), .in_data(8'h77),
        .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data),
        .out_was_compressed(s_out_comp), .err_miss(s_err_miss),
        .stat_compressed(s_stat_comp), .stat_raw(s_stat_raw),
        .stat_clear(1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic dict_write(input logic [3:0] addr, input logic [7:0] data);
        dict_we    = 1'b1;
        dict_waddr = addr;
        dict_wdata = data;
        cycle();
        dict_we    = 1'b0;
    endtask

    task automatic drive_tok(input logic comp, input logic [7:0] data);
        in_valid      = 1'b1;
        in_compressed = comp;
        in_data       = data;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        resetn = 1'b0;
        dict_we = 1'b0; dict_waddr = '0; dict_wdata = '0;
        in_valid = 1'b0; in_compressed = 1'b0; in_data = '0;
        out_ready = 1'b1; stat_clear = 1'b0; s_in_valid = 1'b0;
        cycle();
        cycle();
        resetn = 1'b1;

        check("rst_in_ready",  in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data, 0);
        check("rst_out_comp",  out_was_compressed, 0);
        check("rst_err_miss",  err_miss, 0);
        check("rst_stat_c",    stat_compressed, 0);
        check("rst_stat_r",    stat_raw, 0);

        // Basic stream: key 1, raw A5, key 5
        dict_write(4'd1, 8'h02);
        dict_write(4'd5, 8'h06);
        drive_tok(1'b1, 8'h01);
        cycle();
        drive_tok(1'b0, 8'hA5);
        cycle();
        drive_tok(1'b1, 8'h05);
        check("s_o1_valid", out_valid, 1);
        check("s_o1_data",  out_data, 8'h02);
        check("s_o1_comp",  out_was_compressed, 1);
        cycle();
        in_valid = 1'b0;
        check("s_o2_data",  out_data, 8'hA5);
        check("s_o2_comp",  out_was_compressed, 0);
        cycle();
        check("s_o3_data",  out_data, 8'h06);
        check("s_o3_comp",  out_was_compressed, 1);
        cycle();
        check("s_idle",     out_valid, 0);
        check("s_stat_c",   stat_compressed, 2);
        check("s_stat_r",   stat_raw, 1);

        // Miss on never-written key 3
        drive_tok(1'b1, 8'h03);
        cycle();
        in_valid = 1'b0;
        cycle();
        check("m_valid", out_valid, 1);
        check("m_data",  out_data, 0);
        check("m_comp",  out_was_compressed, 1);
        check("m_err",   err_miss, 1);
        cycle();
        cycle();
        check("m_err_sticky", err_miss, 1);
        check("m_stat_c",     stat_compressed, 3);
        stat_clear = 1'b1;
        cycle();
        stat_clear = 1'b0;
        check("clr_err",    err_miss, 0);
        check("clr_stat_c", stat_compressed, 0);
        check("clr_stat_r", stat_raw, 0);

        // Backpressure: four raw tokens, out_ready low
        out_ready = 1'b0;
        drive_tok(1'b0, 8'h10);
        check("bp_rdy0", in_ready, 1);
        cycle();
        drive_tok(1'b0, 8'h11);
        check("bp_rdy1", in_ready, 1);
        cycle();
        drive_tok(1'b0, 8'h12);
        check("bp_rdy2", in_ready, 0);
        check("bp_hold0", out_data, 8'h10);
        cycle();
        check("bp_rdy3", in_ready, 0);
        check("bp_hold1", out_data, 8'h10);
        check("bp_hold_v", out_valid, 1);
        out_ready = 1'b1;
        #1;
        check("bp_rdy_rel", in_ready, 1);
        cycle();
        drive_tok(1'b0, 8'h13);
        check("bp_d1", out_data, 8'h11);
        cycle();
        in_valid = 1'b0;
        check("bp_d2", out_data, 8'h12);
        cycle();
        check("bp_d3", out_data, 8'h13);
        check("bp_d3_v", out_valid, 1);
        cycle();
        check("bp_empty", out_valid, 0);
        check("bp_stat_r", stat_raw, 4);

        // Write/lookup collision on key 7
        dict_write(4'd7, 8'h11);
        drive_tok(1'b1, 8'h07);
        cycle();
        in_valid   = 1'b0;
        dict_we    = 1'b1;
        dict_waddr = 4'd7;
        dict_wdata = 8'h3C;
        cycle();
        dict_we = 1'b0;
        check("col_data", out_data, 8'h3C);
        check("col_err",  err_miss, 0);
        drive_tok(1'b1, 8'h07);
        cycle();
        in_valid = 1'b0;
        cycle();
        check("col_after", out_data, 8'h3C);
        cycle();

        // Reset with both stages full
        dict_write(4'd2, 8'h55);
        out_ready = 1'b0;
        drive_tok(1'b1, 8'h02);
        cycle();
        cycle();
        in_valid = 1'b0;
        check("full_v",   out_valid, 1);
        check("full_rdy", in_ready, 0);
        check("full_d",   out_data, 8'h55);
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        out_ready = 1'b1;
        check("mr_valid",  out_valid, 0);
        check("mr_rdy",    in_ready, 1);
        check("mr_stat_c", stat_compressed, 0);
        check("mr_stat_r", stat_raw, 0);
        drive_tok(1'b1, 8'h02);
        cycle();
        in_valid = 1'b0;
        cycle();
        check("mr_miss_d", out_data, 0);
        check("mr_miss_e", err_miss, 1);
        cycle();

        // Saturation with 2-bit counters
        s_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        s_in_valid = 1'b0;
        cycle();
        cycle();
        check("sat_raw",  s_stat_raw, 3);
        check("sat_comp", s_stat_comp, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
